// File: rtl/aes3_tx_block_if.sv
// Sample-pair handshake between the audio source and the AES3 transmitter.
interface aes3_tx_block_if #(
  parameter int SAMPLE_WIDTH = 24
) ();
  logic                    sample_valid;
  logic                    sample_ready;
  logic [SAMPLE_WIDTH-1:0] channel_a;
  logic [SAMPLE_WIDTH-1:0] channel_b;
  logic                    validity_a;
  logic                    validity_b;

  // Audio source side
  modport master (
    output sample_valid,
    output channel_a,
    output channel_b,
    output validity_a,
    output validity_b,
    input  sample_ready
  );

  // Transmitter side
  modport slave (
    input  sample_valid,
    input  channel_a,
    input  channel_b,
    input  validity_a,
    input  validity_b,
    output sample_ready
  );
endinterface

// File: rtl/aes3_tx_block.sv
// AES3 / S-PDIF biphase-mark transmitter with configurable sample width,
// one-pair holding register, per-channel validity and 192-frame channel status.
module aes3_tx_block #(
  parameter int SAMPLE_WIDTH = 24,
  parameter bit CS_ENABLE    = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_en,
  aes3_tx_block_if.slave      smp,
  input  logic [191:0]        cs_a,
  input  logic [191:0]        cs_b,
  output logic                sdo,
  output logic                frame_sync,
  output logic                block_sync,
  output logic                underrun
);

  // Number of zero LSBs below the sample inside the 24-bit aux+audio field
  localparam int PAD = 24 - SAMPLE_WIDTH;

  localparam logic [7:0] PRE_Z = 8'b11101000;
  localparam logic [7:0] PRE_X = 8'b11100010;
  localparam logic [7:0] PRE_Y = 8'b11100100;

  typedef enum logic {SUB_A = 1'b0, SUB_B = 1'b1} sub_t;

  // Position counters
  logic [5:0]  cell_q, cell_d;
  sub_t        sub_q, sub_d;
  logic [7:0]  frame_q, frame_d;

  // Holding register (filled by the handshake)
  logic                    hold_full_q, hold_full_d;
  logic [SAMPLE_WIDTH-1:0] hold_a_q, hold_a_d;
  logic [SAMPLE_WIDTH-1:0] hold_b_q, hold_b_d;
  logic                    hold_va_q, hold_va_d;
  logic                    hold_vb_q, hold_vb_d;

  // Working pair (the frame currently on the wire), already MSB-aligned
  logic [23:0] work_a_q, work_a_d;
  logic [23:0] work_b_q, work_b_d;
  logic        work_va_q, work_va_d;
  logic        work_vb_q, work_vb_d;

  // Channel-status block latched at the start of each block
  logic [191:0] csblk_a_q, csblk_a_d;
  logic [191:0] csblk_b_q, csblk_b_d;

  // Line state and registered outputs
  logic pol_q, pol_d;
  logic sdo_q, sdo_d;
  logic frame_sync_q, frame_sync_d;
  logic block_sync_q, block_sync_d;
  logic underrun_q, underrun_d;
  logic ready_q, ready_d;

  // Per-cell datapath
  logic [4:0]  slot;
  logic [23:0] field;
  logic        v_bit;
  logic        c_bit;
  logic        p_bit;
  logic [31:0] slot_bits;
  logic [7:0]  preamble;
  logic        pre_pol;
  logic        cell_level;
  logic        load_tick;

  assign sdo              = sdo_q;
  assign frame_sync       = frame_sync_q;
  assign block_sync       = block_sync_q;
  assign underrun         = underrun_q;
  assign smp.sample_ready = ready_q;

  // Line level for the current cell: preamble pattern or biphase-mark data
  always_comb begin
    slot      = cell_q[5:1];
    field     = (sub_q == SUB_B) ? work_b_q  : work_a_q;
    v_bit     = (sub_q == SUB_B) ? work_vb_q : work_va_q;
    c_bit     = 1'b0;
    if (CS_ENABLE) begin
      c_bit = (sub_q == SUB_B) ? csblk_b_q[frame_q] : csblk_a_q[frame_q];
    end
    // Even parity over slots 4..31; U is always 0 so it does not contribute
    p_bit     = ^{field, v_bit, c_bit};
    slot_bits = {p_bit, c_bit, 1'b0, v_bit, field, 4'b0000};

    if (sub_q == SUB_B) begin
      preamble = PRE_Y;
    end else if (frame_q == 8'd0) begin
      preamble = PRE_Z;
    end else begin
      preamble = PRE_X;
    end
    // Preamble polarity follows the line level left by the previous subframe
    pre_pol = (cell_q == 6'd0) ? sdo_q : pol_q;

    if (cell_q < 6'd8) begin
      cell_level = preamble[~cell_q[2:0]] ^ pre_pol;
    end else if (!cell_q[0]) begin
      cell_level = ~sdo_q;
    end else begin
      cell_level = sdo_q ^ slot_bits[slot];
    end

    load_tick = shift_en && (sub_q == SUB_A) && (cell_q == 6'd7);
  end

  // Next-state: counters, sample/status loads and the handshake
  always_comb begin
    cell_d       = cell_q;
    sub_d        = sub_q;
    frame_d      = frame_q;
    hold_full_d  = hold_full_q;
    hold_a_d     = hold_a_q;
    hold_b_d     = hold_b_q;
    hold_va_d    = hold_va_q;
    hold_vb_d    = hold_vb_q;
    work_a_d     = work_a_q;
    work_b_d     = work_b_q;
    work_va_d    = work_va_q;
    work_vb_d    = work_vb_q;
    csblk_a_d    = csblk_a_q;
    csblk_b_d    = csblk_b_q;
    pol_d        = pol_q;
    sdo_d        = sdo_q;
    frame_sync_d = 1'b0;
    block_sync_d = 1'b0;
    underrun_d   = 1'b0;

    if (shift_en) begin
      sdo_d = cell_level;
      if (cell_q == 6'd0) begin
        pol_d = sdo_q;
      end
      if (cell_q == 6'd63) begin
        cell_d = 6'd0;
        if (sub_q == SUB_B) begin
          sub_d        = SUB_A;
          frame_sync_d = 1'b1;
          if (frame_q == 8'd191) begin
            block_sync_d = 1'b1;
            frame_d      = 8'd0;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end else begin
          sub_d = SUB_B;
        end
      end else begin
        cell_d = cell_q + 6'd1;
      end
    end

    // The working pair is swapped in just before the first data slot of A
    if (load_tick) begin
      if (hold_full_q) begin
        work_a_d    = 24'(hold_a_q) << PAD;
        work_b_d    = 24'(hold_b_q) << PAD;
        work_va_d   = hold_va_q;
        work_vb_d   = hold_vb_q;
        hold_full_d = 1'b0;
      end else begin
        work_a_d    = 24'd0;
        work_b_d    = 24'd0;
        work_va_d   = 1'b1;
        work_vb_d   = 1'b1;
        underrun_d  = 1'b1;
      end
      if (frame_q == 8'd0) begin
        csblk_a_d = cs_a;
        csblk_b_d = cs_b;
      end
    end

    // ready_q is low whenever the holding register is full, so a capture
    // never coincides with a transfer out of it
    if (smp.sample_valid && ready_q) begin
      hold_a_d    = smp.channel_a;
      hold_b_d    = smp.channel_b;
      hold_va_d   = smp.validity_a;
      hold_vb_d   = smp.validity_b;
      hold_full_d = 1'b1;
    end

    ready_d = ~hold_full_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      cell_q       <= 6'd0;
      sub_q        <= SUB_A;
      frame_q      <= 8'd0;
      hold_full_q  <= 1'b0;
      hold_a_q     <= '0;
      hold_b_q     <= '0;
      hold_va_q    <= 1'b0;
      hold_vb_q    <= 1'b0;
      work_a_q     <= 24'd0;
      work_b_q     <= 24'd0;
      work_va_q    <= 1'b0;
      work_vb_q    <= 1'b0;
      csblk_a_q    <= 192'd0;
      csblk_b_q    <= 192'd0;
      pol_q        <= 1'b0;
      sdo_q        <= 1'b0;
      frame_sync_q <= 1'b0;
      block_sync_q <= 1'b0;
      underrun_q   <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      cell_q       <= cell_d;
      sub_q        <= sub_d;
      frame_q      <= frame_d;
      hold_full_q  <= hold_full_d;
      hold_a_q     <= hold_a_d;
      hold_b_q     <= hold_b_d;
      hold_va_q    <= hold_va_d;
      hold_vb_q    <= hold_vb_d;
      work_a_q     <= work_a_d;
      work_b_q     <= work_b_d;
      work_va_q    <= work_va_d;
      work_vb_q    <= work_vb_d;
      csblk_a_q    <= csblk_a_d;
      csblk_b_q    <= csblk_b_d;
      pol_q        <= pol_d;
      sdo_q        <= sdo_d;
      frame_sync_q <= frame_sync_d;
      block_sync_q <= block_sync_d;
      underrun_q   <= underrun_d;
      ready_q      <= ready_d;
    end
  end

endmodule

// File: doc/aes3_tx_block.md
Name: aes3_tx_block

Overview:
Parametrised AES3/S-PDIF biphase-mark transmitter. Adds to the earlier fixed 24-bit transmitter:
- configurable sample width;
- a valid/ready sample handshake with a one-pair holding register and underrun signalling;
- per-channel validity bits;
- a full 192-frame channel-status block per channel, with a block-start strobe.

It sits between the audio sample source (mixer/FIFO) and the output pin driver. The serial half-bit rate is set by shift_en.

Parameters:
SAMPLE_WIDTH, 24, audio bits per channel. Legal range 16..24. Samples are MSB-aligned into the 24-bit aux+audio field; unused LSBs are sent as 0.
CS_ENABLE, 1, 1 = send cs_a/cs_b bits in slot 30; 0 = slot 30 is always 0.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
shift_en  in  1  one-cycle enable per half-bit cell; tie high if clk is the half-bit clock
sample_valid  in  1  a sample pair is presented
sample_ready  out  1  holding register empty; a pair is accepted when valid&&ready at a clk edge
channel_a  in  SAMPLE_WIDTH  channel A sample
channel_b  in  SAMPLE_WIDTH  channel B sample
validity_a  in  1  V bit for channel A (1 = not valid), captured with the sample
validity_b  in  1  V bit for channel B, captured with the sample
cs_a  in  192  channel-status block for A; bit n is sent in frame n
cs_b  in  192  channel-status block for B
sdo  out  1  biphase-mark serial output
frame_sync  out  1  one-cycle pulse after the last cell of subframe B
block_sync  out  1  one-cycle pulse after the last cell of frame 191
underrun  out  1  one-cycle pulse when a frame starts with the holding register empty

Behaviour:
- Reset values:
  - sdo=0, frame_sync=0, block_sync=0, underrun=0.
  - Holding register empty, so sample_ready=1 from the next cycle.
  - frame=0, subframe=A, cell=0.
- Reset mid-subframe aborts the subframe immediately; no partial completion.
- Counters advance only on cycles with shift_en=1:
  - cell 0..63 (half-bit cells);
  - subframe A/B;
  - frame 0..191, wrapping to 0.
- Slot map (slot = cell/2):
  - slots 0-3: preamble;
  - slots 4-27: 24-bit field, LSB first; sample bit i is at field bit i+24-SAMPLE_WIDTH;
  - slot 28: V;
  - slot 29: U (always 0);
  - slot 30: C = cs_x[frame] if CS_ENABLE, else 0;
  - slot 31: P.
- Preamble encoding (8 cells, written as line levels, given last sdo=0; complement every cell if last sdo=1):
  - Z = 11101000, used for subframe A of frame 0;
  - X = 11100010, used for subframe A of other frames;
  - Y = 11100100, used for subframe B.
- Data cells:
  - first half of each slot toggles sdo;
  - second half toggles sdo iff the bit is 1.
- Parity: P makes the count of ones in slots 4-31 even, so sdo is 0 at the end of every subframe after the first.
- Sample load, on the shift_en tick of cell 7 of subframe A:
  - If the holding register is full: holding moves to the working pair and the holding register empties.
  - If empty: the working pair = zeros with V=1 on both channels, and underrun pulses that cycle.
  - Subframe B uses the channel B half of the same working pair.
- Channel status load: cs_a/cs_b are captured into internal block registers on the cell-7 tick of subframe A, frame 0. Mid-block changes to cs_a/cs_b have no effect until the next block.
- Handshake:
  - sample_ready = holding empty (registered).
  - A capture and a transfer in the same cycle cannot happen, because ready=0 whenever a transfer empties the holding register; sample_ready rises the next cycle.
  - valid without ready: the source must hold the data; no data is dropped.
- frame_sync pulses on the cycle after the cell-63 tick of subframe B.
- block_sync pulses together with frame_sync when frame=191.

Test Plan:
1. Reset, then tie shift_en=1 with sample_valid=0 → first 8 sdo cells are 11101000 (Z); underrun pulses on clk 8; all data slots carry 0 except V=1; parity gives even ones; sdo=0 at cell 63.
2. SAMPLE_WIDTH=16, present A=0x8001, B=0x1234 before the first frame → slots 4-11 of A are 0; field bit 8 = 1 and bit 23 = 1; B carries 0x123400 LSB first; P is correct.
3. shift_en pulsing every 4th clk → sdo changes only on enabled cycles; waveform matches case 1 cell-for-cell; frame_sync is exactly 1 clk wide.
4. Set cs_a bit0=1, bit191=1, cs_b=0; run 2 blocks → slot 30 of A is 1 in frames 0 and 191; Z appears only in frame 0; block_sync fires once per 192 frame_syncs. Changing cs_a mid-block is not seen until the next block.
5. Keep sample_valid=1 continuously → exactly one pair is accepted per frame; sample_ready is low from acceptance until the cell-7 transfer; no underrun.
6. Assert rst at cell 30 of subframe B → next cycle all outputs are at reset values; the next cells restart with the Z preamble.
